// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared types, defaults and timing-set validation for video_timing_gen
// Contents:
//   CNT_W_DEFAULT   default counter / timing field width
//   state_t         frame FSM states (IDLE / RUN / DONE)
//   timing_set_t    shadowed per-axis timing set {total, sync, act_start, act_end}
//   axis_ok()       checks one axis of a live timing set before it may be latched
package video_timing_pkg;

    localparam int CNT_W_DEFAULT = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [CNT_W_DEFAULT-1:0] total;
        logic [CNT_W_DEFAULT-1:0] sync;
        logic [CNT_W_DEFAULT-1:0] act_start;
        logic [CNT_W_DEFAULT-1:0] act_end;
    } timing_set_t;

    // Arguments are zero-extended to 32 bits by the caller, so the three-term
    // sum cannot wrap for any supported field width.
    function automatic logic axis_ok(
        input int unsigned total,
        input int unsigned sync,
        input int unsigned bporch,
        input int unsigned res
    );
        return (sync >= 1) && (res >= 1) && (sync + bporch + res <= total);
    endfunction

endpackage

// File: rtl/video_timing_axis.sv
// rtl/video_timing_axis.sv - one raster axis: shadowed timing set and position decode
// Ports:
//   clk, rst        pixel clock, synchronous active-high reset
//   load            latch the live timing fields into the shadow set
//   total/sync/bporch/res   live timing fields for this axis
//   count           current position on this axis
//   last            count is the last position (total-1)
//   sync_act        count inside the sync window
//   active          count inside the active window
//   last_active     count is the last active position
//   index           offset into the active window, 0 outside it
module video_timing_axis
    import video_timing_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] total,
    input  logic [CNT_W-1:0] sync,
    input  logic [CNT_W-1:0] bporch,
    input  logic [CNT_W-1:0] res,
    input  logic [CNT_W-1:0] count,
    output logic             last,
    output logic             sync_act,
    output logic             active,
    output logic             last_active,
    output logic [CNT_W-1:0] index
);

    logic [CNT_W-1:0] total_r;
    logic [CNT_W-1:0] sync_r;
    logic [CNT_W-1:0] start_r;
    logic [CNT_W-1:0] end_r;

    // Only loaded after the set has been validated, so these sums fit in CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_r <= '0;
            sync_r  <= '0;
            start_r <= '0;
            end_r   <= '0;
        end else if (load) begin
            total_r <= total;
            sync_r  <= sync;
            start_r <= sync + bporch;
            end_r   <= sync + bporch + res;
        end
    end

    always_comb begin
        last        = (count == total_r - CNT_W'(1));
        sync_act    = (count < sync_r);
        active      = (count >= start_r) && (count < end_r);
        last_active = (count == end_r - CNT_W'(1));
        index       = active ? (count - start_r) : '0;
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with shadowed timing and registered outputs
// Ports:
//   I_pxl_clk, I_rst          pixel clock, synchronous active-high reset
//   I_en, I_cont              start / keep-running enable, free-run select
//   I_h_* / I_v_*             live timing fields (total, sync, bporch, res) per axis
//   O_busy                    frame in progress (RUN and DONE)
//   O_de, O_hs, O_vs          active video and syncs (sync polarity from HS_POL / VS_POL)
//   O_x, O_y                  active-area coordinates, 0 outside active video
//   O_sof, O_eol              start-of-frame and last-active-pixel strobes
//   O_cfg_err                 start refused because the live timing set is invalid
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input  logic             I_pxl_clk,
    input  logic             I_rst,
    input  logic             I_en,
    input  logic             I_cont,
    input  logic [CNT_W-1:0] I_h_total,
    input  logic [CNT_W-1:0] I_h_sync,
    input  logic [CNT_W-1:0] I_h_bporch,
    input  logic [CNT_W-1:0] I_h_res,
    input  logic [CNT_W-1:0] I_v_total,
    input  logic [CNT_W-1:0] I_v_sync,
    input  logic [CNT_W-1:0] I_v_bporch,
    input  logic [CNT_W-1:0] I_v_res,
    output logic             O_busy,
    output logic             O_de,
    output logic             O_hs,
    output logic             O_vs,
    output logic [CNT_W-1:0] O_x,
    output logic [CNT_W-1:0] O_y,
    output logic             O_sof,
    output logic             O_eol,
    output logic             O_cfg_err
);

    state_t           state;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    logic             cfg_ok;
    logic             keep_running;
    logic             load;
    logic             h_last, h_sync, h_active, h_last_active;
    logic             v_last, v_sync, v_active, v_last_active_unused;
    logic [CNT_W-1:0] h_index, v_index;

    assign cfg_ok = axis_ok(32'(I_h_total), 32'(I_h_sync), 32'(I_h_bporch), 32'(I_h_res)) &&
                    axis_ok(32'(I_v_total), 32'(I_v_sync), 32'(I_v_bporch), 32'(I_v_res));

    assign keep_running = I_cont && I_en && cfg_ok;

    // Shadow sets change only when a frame begins: on start, or on the
    // free-running wrap from the last pixel straight back to (0,0).
    assign load = ((state == ST_IDLE) && I_en && cfg_ok) ||
                  ((state == ST_RUN) && h_last && v_last && keep_running);

    video_timing_axis #(.CNT_W(CNT_W)) u_h_axis (
        .clk         (I_pxl_clk),
        .rst         (I_rst),
        .load        (load),
        .total       (I_h_total),
        .sync        (I_h_sync),
        .bporch      (I_h_bporch),
        .res         (I_h_res),
        .count       (h_cnt),
        .last        (h_last),
        .sync_act    (h_sync),
        .active      (h_active),
        .last_active (h_last_active),
        .index       (h_index)
    );

    // The vertical last-active flag has no consumer: end-of-line is a horizontal event.
    video_timing_axis #(.CNT_W(CNT_W)) u_v_axis (
        .clk         (I_pxl_clk),
        .rst         (I_rst),
        .load        (load),
        .total       (I_v_total),
        .sync        (I_v_sync),
        .bporch      (I_v_bporch),
        .res         (I_v_res),
        .count       (v_cnt),
        .last        (v_last),
        .sync_act    (v_sync),
        .active      (v_active),
        .last_active (v_last_active_unused),
        .index       (v_index)
    );

    // Frame FSM and raster counters.
    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            state     <= ST_IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            O_busy    <= 1'b0;
            O_cfg_err <= 1'b0;
        end else begin
            O_cfg_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (I_en) begin
                        if (cfg_ok) begin
                            state  <= ST_RUN;
                            h_cnt  <= '0;
                            v_cnt  <= '0;
                            O_busy <= 1'b1;
                        end else begin
                            O_cfg_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (h_last) begin
                        h_cnt <= '0;
                        if (v_last) begin
                            v_cnt <= '0;
                            if (!keep_running) begin
                                state <= ST_DONE;
                                // A free-run continuation refused for bad timing is reported too.
                                O_cfg_err <= I_cont && I_en && !cfg_ok;
                            end
                        end else begin
                            v_cnt <= v_cnt + CNT_W'(1);
                        end
                    end else begin
                        h_cnt <= h_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    O_busy <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    O_busy <= 1'b0;
                end
            endcase
        end
    end

    // Output stage: one register behind the counters; idle levels outside RUN.
    always_ff @(posedge I_pxl_clk) begin
        if (I_rst || (state != ST_RUN)) begin
            O_de  <= 1'b0;
            O_hs  <= ~HS_POL;
            O_vs  <= ~VS_POL;
            O_x   <= '0;
            O_y   <= '0;
            O_sof <= 1'b0;
            O_eol <= 1'b0;
        end else begin
            O_de  <= h_active && v_active;
            O_hs  <= h_sync ? HS_POL : ~HS_POL;
            O_vs  <= v_sync ? VS_POL : ~VS_POL;
            O_x   <= (h_active && v_active) ? h_index : '0;
            O_y   <= (h_active && v_active) ? v_index : '0;
            O_sof <= (h_cnt == '0) && (v_cnt == '0);
            O_eol <= h_last_active && v_active;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen against a raster arithmetic model
module tb_video_timing_gen;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          cont = 1'b0;
    logic [CW-1:0] h_total = '0, h_sync = '0, h_bporch = '0, h_res = '0;
    logic [CW-1:0] v_total = '0, v_sync = '0, v_bporch = '0, v_res = '0;

    logic          busy, de, hs, vs, sof, eol, cfg_err;
    logic [CW-1:0] x, y;
    logic          n_busy, n_de, n_hs, n_vs, n_sof, n_eol, n_cfg_err;
    logic [CW-1:0] n_x, n_y;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    video_timing_gen u_dut (
        .I_pxl_clk(clk), .I_rst(rst), .I_en(en), .I_cont(cont),
        .I_h_total(h_total), .I_h_sync(h_sync), .I_h_bporch(h_bporch), .I_h_res(h_res),
        .I_v_total(v_total), .I_v_sync(v_sync), .I_v_bporch(v_bporch), .I_v_res(v_res),
        .O_busy(busy), .O_de(de), .O_hs(hs), .O_vs(vs), .O_x(x), .O_y(y),
        .O_sof(sof), .O_eol(eol), .O_cfg_err(cfg_err)
    );

    video_timing_gen #(.HS_POL(1'b0), .VS_POL(1'b0)) u_neg (
        .I_pxl_clk(clk), .I_rst(rst), .I_en(en), .I_cont(cont),
        .I_h_total(h_total), .I_h_sync(h_sync), .I_h_bporch(h_bporch), .I_h_res(h_res),
        .I_v_total(v_total), .I_v_sync(v_sync), .I_v_bporch(v_bporch), .I_v_res(v_res),
        .O_busy(n_busy), .O_de(n_de), .O_hs(n_hs), .O_vs(n_vs), .O_x(n_x), .O_y(n_y),
        .O_sof(n_sof), .O_eol(n_eol), .O_cfg_err(n_cfg_err)
    );

    function automatic logic [61:0] observed();
        return {busy, de, hs, vs, sof, eol, cfg_err, x, y,
                n_busy, n_de, n_hs, n_vs, n_sof, n_eol, n_cfg_err, n_x, n_y};
    endfunction

    // Expected view of both instances; the second one has inverted sync polarity.
    function automatic logic [61:0] exp_vec(input logic b, input logic d, input logic hsa,
                                            input logic vsa, input logic s, input logic e,
                                            input logic c, input int ex, input int ey);
        logic [CW-1:0] xx, yy;
        xx = CW'(ex);
        yy = CW'(ey);
        return {b, d, hsa, vsa, s, e, c, xx, yy, b, d, ~hsa, ~vsa, s, e, c, xx, yy};
    endfunction

    function automatic logic [61:0] idle_vec(input logic b, input logic c);
        return exp_vec(b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c, 0, 0);
    endfunction

    // Pixel k of a frame: position from raster arithmetic, decode from the timing rules.
    function automatic logic [61:0] model(input int ht, input int hs_w, input int hb, input int hr,
                                          input int vs_w, input int vb, input int vr, input int k);
        int h, v, hst, vst;
        logic d;
        h   = k % ht;
        v   = k / ht;
        hst = hs_w + hb;
        vst = vs_w + vb;
        d   = (h >= hst) && (h < hst + hr) && (v >= vst) && (v < vst + vr);
        return exp_vec(1'b1, d, h < hs_w, v < vs_w, k == 0, d && (h == hst + hr - 1), 1'b0,
                       d ? h - hst : 0, d ? v - vst : 0);
    endfunction

    task automatic set_timing(input int ht, input int hs_w, input int hb, input int hr,
                              input int vt, input int vs_w, input int vb, input int vr);
        h_total = CW'(ht); h_sync = CW'(hs_w); h_bporch = CW'(hb); h_res = CW'(hr);
        v_total = CW'(vt); v_sync = CW'(vs_w); v_bporch = CW'(vb); v_res = CW'(vr);
    endtask

    task automatic pulse_en();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    // One single-shot frame, checked cycle by cycle; returns activity tallies from the DUT.
    task automatic run_frame(input string name,
                             input int ht, input int hs_w, input int hb, input int hr,
                             input int vt, input int vs_w, input int vb, input int vr,
                             output int de_c, output int hs_c, output int vs_c, output int sof_c,
                             output int eol_c, output int busy_c, output int xmax, output int ymax);
        logic [61:0] e;
        int n;
        n = ht * vt;
        de_c = 0; hs_c = 0; vs_c = 0; sof_c = 0; eol_c = 0; busy_c = 0; xmax = 0; ymax = 0;
        set_timing(ht, hs_w, hb, hr, vt, vs_w, vb, vr);
        pulse_en();
        checks++;
        if (observed() !== idle_vec(1'b1, 1'b0))
            $display("FAIL %s start: got %h want %h", name, observed(), idle_vec(1'b1, 1'b0));
        else passes++;
        busy_c += int'(busy);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e = model(ht, hs_w, hb, hr, vs_w, vb, vr, k);
            checks++;
            if (observed() !== e)
                $display("FAIL %s pixel %0d: got %h want %h", name, k, observed(), e);
            else passes++;
            de_c += int'(de); hs_c += int'(hs); vs_c += int'(vs);
            sof_c += int'(sof); eol_c += int'(eol); busy_c += int'(busy);
            if (int'(x) > xmax) xmax = int'(x);
            if (int'(y) > ymax) ymax = int'(y);
        end
        @(negedge clk);
        checks++;
        if (observed() !== idle_vec(1'b0, 1'b0))
            $display("FAIL %s end: got %h want %h", name, observed(), idle_vec(1'b0, 1'b0));
        else passes++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (observed() !== idle_vec(1'b0, 1'b0))
            $display("FAIL reset_state: got %h want %h", observed(), idle_vec(1'b0, 1'b0));
        else passes++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int dc, hc, vc, sc, ec, bc, xm, ym;
        run_frame("single", 16, 2, 3, 8, 10, 1, 2, 5, dc, hc, vc, sc, ec, bc, xm, ym);
        checks++; if (bc !== 161) $display("FAIL single_busy: got %0d want 161", bc); else passes++;
        checks++; if (dc !== 40)  $display("FAIL single_de: got %0d want 40", dc);    else passes++;
        checks++; if (hc !== 20)  $display("FAIL single_hs: got %0d want 20", hc);    else passes++;
        checks++; if (vc !== 16)  $display("FAIL single_vs: got %0d want 16", vc);    else passes++;
        checks++; if (sc !== 1)   $display("FAIL single_sof: got %0d want 1", sc);    else passes++;
        checks++; if (ec !== 5)   $display("FAIL single_eol: got %0d want 5", ec);    else passes++;
        checks++; if (xm !== 7)   $display("FAIL single_xmax: got %0d want 7", xm);   else passes++;
        checks++; if (ym !== 4)   $display("FAIL single_ymax: got %0d want 4", ym);   else passes++;
    endtask

    task automatic test_boundaries();
        int dc, hc, vc, sc, ec, bc, xm, ym;
        // Porches of zero with sync+bporch+res == total on both axes.
        run_frame("tight", 4, 1, 0, 3, 3, 1, 0, 2, dc, hc, vc, sc, ec, bc, xm, ym);
        checks++; if (dc !== 6) $display("FAIL tight_de: got %0d want 6", dc); else passes++;
        // Smallest legal raster.
        run_frame("minimal", 2, 1, 0, 1, 2, 1, 0, 1, dc, hc, vc, sc, ec, bc, xm, ym);
        checks++; if (bc !== 5) $display("FAIL minimal_busy: got %0d want 5", bc); else passes++;
    endtask

    task automatic test_random();
        int ht, hs_w, hb, hr, vt, vs_w, vb, vr;
        int dc, hc, vc, sc, ec, bc, xm, ym;
        for (int i = 0; i < 6; i++) begin
            hs_w = int'($urandom_range(1, 3)); hb = int'($urandom_range(0, 3));
            hr   = int'($urandom_range(1, 6)); ht = hs_w + hb + hr + int'($urandom_range(0, 3));
            vs_w = int'($urandom_range(1, 2)); vb = int'($urandom_range(0, 2));
            vr   = int'($urandom_range(1, 4)); vt = vs_w + vb + vr + int'($urandom_range(0, 2));
            run_frame("random", ht, hs_w, hb, hr, vt, vs_w, vb, vr, dc, hc, vc, sc, ec, bc, xm, ym);
            checks++;
            if (dc !== hr * vr) $display("FAIL random_de: got %0d want %0d", dc, hr * vr);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [61:0] e;
        int n, hr_f, last_sof, gap_err;
        n = 160; last_sof = -1; gap_err = 0;
        set_timing(16, 2, 3, 8, 10, 1, 2, 5);
        cont = 1'b1;
        en = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            hr_f = (f == 0) ? 8 : 6;
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                e = model(16, 2, 3, hr_f, 1, 2, 5, k);
                checks++;
                if (observed() !== e)
                    $display("FAIL cont frame %0d pixel %0d: got %h want %h", f, k, observed(), e);
                else passes++;
                if (sof) begin
                    if (last_sof >= 0 && (f * n + k) - last_sof != n) gap_err++;
                    last_sof = f * n + k;
                end
                if (f == 0 && k == n / 2) h_res = CW'(6);
                if (f == 1 && k == n / 2) en = 1'b0;
            end
        end
        checks++;
        if (gap_err !== 0 || last_sof !== n) $display("FAIL cont_sof_spacing: got last %0d errs %0d want %0d", last_sof, gap_err, n);
        else passes++;
        @(negedge clk);
        checks++;
        if (observed() !== idle_vec(1'b0, 1'b0))
            $display("FAIL cont_end: got %h want %h", observed(), idle_vec(1'b0, 1'b0));
        else passes++;
        cont = 1'b0;
    endtask

    task automatic test_cfg_err();
        int pulses;
        int bad [3][8] = '{'{16, 2, 3, 12, 10, 1, 2, 5},
                           '{16, 0, 3, 8, 10, 1, 2, 5},
                           '{16, 2, 3, 8, 10, 1, 2, 0}};
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            set_timing(bad[i][0], bad[i][1], bad[i][2], bad[i][3],
                       bad[i][4], bad[i][5], bad[i][6], bad[i][7]);
            pulse_en();
            checks++;
            if (observed() !== idle_vec(1'b0, 1'b1))
                $display("FAIL cfg_err_pulse %0d: got %h want %h", i, observed(), idle_vec(1'b0, 1'b1));
            else passes++;
            pulses += int'(cfg_err);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                pulses += int'(cfg_err);
                checks++;
                if (observed() !== idle_vec(1'b0, 1'b0))
                    $display("FAIL cfg_err_idle %0d: got %h want %h", i, observed(), idle_vec(1'b0, 1'b0));
                else passes++;
            end
        end
        checks++;
        if (pulses !== 3) $display("FAIL cfg_err_count: got %0d want 3", pulses); else passes++;
    endtask

    task automatic test_reset_midframe();
        int dc, hc, vc, sc, ec, bc, xm, ym;
        set_timing(16, 2, 3, 8, 10, 1, 2, 5);
        pulse_en();
        // Counters reach h=5, v=3 after 53 more edges.
        repeat (53) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (observed() !== idle_vec(1'b0, 1'b0))
            $display("FAIL reset_midframe: got %h want %h", observed(), idle_vec(1'b0, 1'b0));
        else passes++;
        rst = 1'b0;
        @(negedge clk);
        run_frame("after_reset", 16, 2, 3, 8, 10, 1, 2, 5, dc, hc, vc, sc, ec, bc, xm, ym);
        checks++; if (sc !== 1) $display("FAIL after_reset_sof: got %0d want 1", sc); else passes++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_boundaries();
        test_random();
        test_back_to_back();
        test_cfg_err();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
